// File: rtl/pipe_ctrl_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_unit_pkg
// Brief    : Shared types and constants for the pipeline control unit:
//            fence.i sequencer states, datapath defaults, bubble encoding
//            and a small hazard-match helper.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_ctrl_unit_pkg;

  // Default datapath / PC width and performance counter width.
  localparam int XLEN_DEFAULT  = 32;
  localparam int CNT_W_DEFAULT = 32;

  // Sequential fetch step in bytes.
  localparam int PC_STEP = 4;

  // Canonical NOP (addi x0, x0, 0) used as the bubble injected into EX.
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  localparam logic [4:0]  REG_ZERO = 5'd0;

  // fence.i sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_INVAL  = 2'd2,
    ST_RESUME = 2'd3
  } fence_state_e;

  // True when a source operand is actually read and names the given register.
  function automatic logic src_hits(input logic used, input logic [4:0] src,
                                    input logic [4:0] rd);
    return used && (src == rd);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_unit_branch_resolve.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_unit_branch_resolve
// Brief    : Purely combinational control-flow resolution: actual outcome,
//            corrected fetch PC and mispredict flag versus the IFU prediction.
//            Kept standalone so trace/difftest logic can reuse it.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl_unit_branch_resolve
  import pipe_ctrl_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] result,
  input  logic [XLEN-1:0] branch_pc,
  input  logic            jal,
  input  logic            jalr,
  input  logic            branch,
  input  logic            pred_res,
  input  logic [XLEN-1:0] pred_pc,
  output logic            is_cf,
  output logic [XLEN-1:0] correct,
  output logic            mispredict
);

  logic            taken;
  logic [XLEN-1:0] target;

  // Resolve outcome and compare against the prediction; only control-flow
  // instructions can ever mispredict.
  always_comb begin
    is_cf      = jal | jalr | branch;
    taken      = jal | jalr | (branch & result[0]);
    target     = jalr ? {result[XLEN-1:1], 1'b0} : branch_pc;
    correct    = taken ? target : pc + XLEN'(PC_STEP);
    mispredict = is_cf & ((taken != pred_res) | (taken & (target != pred_pc)));
  end

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_unit
// Brief    : Pipeline sequencer for the 5-stage core. Resolves control flow
//            at EX->LS, issues registered redirect/flush pulses, runs the
//            fence.i drain/invalidate/resume sequence, inserts load-use
//            bubbles and counts resolved branches and mispredicts.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl_unit
  import pipe_ctrl_unit_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ex_fire,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_result,
  input  logic [XLEN-1:0]  ex_branch_pc,
  input  logic             ex_jal,
  input  logic             ex_jalr,
  input  logic             ex_branch,
  input  logic             ex_fence_i,
  input  logic             ex_pred_res,
  input  logic [XLEN-1:0]  ex_pred_pc,
  input  logic             ex_valid,
  input  logic             ex_mem_ren,
  input  logic [4:0]       ex_rd,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             lsu_idle,
  input  logic             icache_flush_done,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush,
  output logic             stall_if,
  output logic             stall_id,
  output logic             icache_flush,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  fence_state_e     state_q, state_d;
  logic             flush_q, flush_d;
  logic             redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
  logic [XLEN-1:0]  fence_pc_q, fence_pc_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic             br_is_cf;
  logic [XLEN-1:0]  br_correct;
  logic             br_mispredict;

  logic             resolve_en;
  logic             fence_hit;
  logic             redirect_hit;
  logic             load_use;

  pipe_ctrl_unit_branch_resolve #(
    .XLEN (XLEN)
  ) u_branch_resolve (
    .pc         (ex_pc),
    .result     (ex_result),
    .branch_pc  (ex_branch_pc),
    .jal        (ex_jal),
    .jalr       (ex_jalr),
    .branch     (ex_branch),
    .pred_res   (ex_pred_res),
    .pred_pc    (ex_pred_pc),
    .is_cf      (br_is_cf),
    .correct    (br_correct),
    .mispredict (br_mispredict)
  );

  // Decide whether the EX instruction is resolved this cycle and what it
  // triggers. A cycle with a pending flush carries wrong-path work only.
  always_comb begin
    resolve_en   = ex_fire & (state_q == ST_IDLE) & ~flush_q;
    fence_hit    = resolve_en & ex_fence_i;
    redirect_hit = resolve_en & ~ex_fence_i & br_mispredict;
    load_use     = ex_valid & ex_mem_ren & (ex_rd != REG_ZERO) & id_valid &
                   (src_hits(id_rs1_used, id_rs1, ex_rd) |
                    src_hits(id_rs2_used, id_rs2, ex_rd));
  end

  // Next values for the redirect/flush pulse, fence return PC and counters.
  always_comb begin
    flush_d          = fence_hit | redirect_hit;
    redirect_valid_d = redirect_hit;
    redirect_pc_d    = redirect_hit ? br_correct : '0;
    // fence.i is not control flow, so the resolver's correct PC is pc+4.
    fence_pc_d       = fence_hit ? br_correct : fence_pc_q;
    branch_cnt_d     = branch_cnt_q + CNT_W'(resolve_en & br_is_cf);
    mispred_cnt_d    = mispred_cnt_q + CNT_W'(redirect_hit);
  end

  // Pulse, PC and counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      fence_pc_q       <= '0;
      branch_cnt_q     <= '0;
      mispred_cnt_q    <= '0;
    end else begin
      flush_q          <= flush_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      fence_pc_q       <= fence_pc_d;
      branch_cnt_q     <= branch_cnt_d;
      mispred_cnt_q    <= mispred_cnt_d;
    end
  end

  // fence.i sequencer state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // fence.i sequencer next state: drain the LSU, invalidate, then refetch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (fence_hit)         state_d = ST_DRAIN;
      ST_DRAIN:  if (lsu_idle)          state_d = ST_INVAL;
      ST_INVAL:  if (icache_flush_done) state_d = ST_RESUME;
      ST_RESUME:                        state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  // Outputs: flush/redirect take priority over the load-use bubble, and the
  // fence sequence holds fetch and issues its own refetch redirect.
  always_comb begin
    stall_id       = load_use & ~flush_q & (state_q == ST_IDLE);
    stall_if       = stall_id | (state_q != ST_IDLE);
    icache_flush   = (state_q == ST_INVAL);
    flush          = flush_q;
    redirect_valid = redirect_valid_q | (state_q == ST_RESUME);
    redirect_pc    = (state_q == ST_RESUME) ? fence_pc_q : redirect_pc_q;
    branch_cnt     = branch_cnt_q;
    mispred_cnt    = mispred_cnt_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl_unit
// Brief    : Self-checking bench for pipe_ctrl_unit: directed vectors with
//            literal expectations plus a per-cycle behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ex_fire = 0;
  logic [31:0] ex_pc = 0, ex_result = 0, ex_branch_pc = 0, ex_pred_pc = 0;
  logic        ex_jal = 0, ex_jalr = 0, ex_branch = 0, ex_fence_i = 0, ex_pred_res = 0;
  logic        ex_valid = 0, ex_mem_ren = 0;
  logic [4:0]  ex_rd = 0, id_rs1 = 0, id_rs2 = 0;
  logic        id_valid = 0, id_rs1_used = 0, id_rs2_used = 0;
  logic        lsu_idle = 1, icache_flush_done = 0;
  logic        redirect_valid, flush, stall_if, stall_id, icache_flush;
  logic [31:0] redirect_pc, branch_cnt, mispred_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_on = 1'b0;

  pipe_ctrl_unit #(.XLEN(32), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .ex_fire(ex_fire), .ex_pc(ex_pc),
    .ex_result(ex_result), .ex_branch_pc(ex_branch_pc), .ex_jal(ex_jal),
    .ex_jalr(ex_jalr), .ex_branch(ex_branch), .ex_fence_i(ex_fence_i),
    .ex_pred_res(ex_pred_res), .ex_pred_pc(ex_pred_pc), .ex_valid(ex_valid),
    .ex_mem_ren(ex_mem_ren), .ex_rd(ex_rd), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used), .lsu_idle(lsu_idle),
    .icache_flush_done(icache_flush_done), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush), .stall_if(stall_if),
    .stall_id(stall_id), .icache_flush(icache_flush),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Expected registered behaviour, tracked as flags for "in drain",
  // "invalidating", "refetching", plus last redirect and counters.
  logic        m_flush, m_rv, m_drain, m_inval, m_resume;
  logic [31:0] m_rpc, m_fpc, m_bcnt, m_mcnt;
  logic        m_busy, m_resolve, m_cf, m_taken, m_mis, m_haz;
  logic [31:0] m_target, m_correct;

  always_comb begin
    m_busy    = m_drain | m_inval | m_resume;
    m_resolve = ex_fire && !m_busy && !m_flush;
    m_cf      = ex_jal | ex_jalr | ex_branch;
    m_taken   = ex_jal | ex_jalr | (ex_branch & ex_result[0]);
    m_target  = ex_jalr ? (ex_result & 32'hFFFF_FFFE) : ex_branch_pc;
    m_correct = m_taken ? m_target : ex_pc + 32'd4;
    m_mis     = m_cf && ((m_taken != ex_pred_res) || (m_taken && m_target != ex_pred_pc));
    m_haz     = ex_valid && ex_mem_ren && ex_rd != 5'd0 && id_valid &&
                ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
  end

  always @(posedge clock) begin
    if (reset) begin
      m_flush <= 0; m_rv <= 0; m_drain <= 0; m_inval <= 0; m_resume <= 0;
      m_rpc <= 0; m_fpc <= 0; m_bcnt <= 0; m_mcnt <= 0;
    end else begin
      m_flush  <= m_resolve && (ex_fence_i || m_mis);
      m_rv     <= m_resolve && !ex_fence_i && m_mis;
      m_rpc    <= m_correct;
      m_drain  <= (m_drain && !lsu_idle) || (m_resolve && ex_fence_i);
      m_inval  <= (m_drain && lsu_idle) || (m_inval && !icache_flush_done);
      m_resume <= m_inval && icache_flush_done;
      if (m_resolve && ex_fence_i) m_fpc <= ex_pc + 32'd4;
      if (m_resolve && m_cf) m_bcnt <= m_bcnt + 32'd1;
      if (m_resolve && m_mis) m_mcnt <= m_mcnt + 32'd1;
    end
  end

  // Compare process: every cycle out of reset, on the inactive edge.
  always @(negedge clock) begin
    if (chk_on && !reset) begin
      logic        e_sid;
      e_sid = m_haz && !m_flush && !m_busy;
      chk("m_flush", {31'd0, flush}, {31'd0, m_flush});
      chk("m_redirect_valid", {31'd0, redirect_valid}, {31'd0, m_rv | m_resume});
      if (m_rv | m_resume) chk("m_redirect_pc", redirect_pc, m_resume ? m_fpc : m_rpc);
      chk("m_stall_id", {31'd0, stall_id}, {31'd0, e_sid});
      chk("m_stall_if", {31'd0, stall_if}, {31'd0, e_sid | m_busy});
      chk("m_icache_flush", {31'd0, icache_flush}, {31'd0, m_inval});
      chk("m_branch_cnt", branch_cnt, m_bcnt);
      chk("m_mispred_cnt", mispred_cnt, m_mcnt);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clr_ex();
    ex_fire = 0; ex_jal = 0; ex_jalr = 0; ex_branch = 0; ex_fence_i = 0;
    ex_pred_res = 0; ex_pred_pc = 0; ex_result = 0; ex_branch_pc = 0; ex_pc = 0;
  endtask

  task automatic clr_haz();
    ex_valid = 0; ex_mem_ren = 0; ex_rd = 0; id_valid = 0;
    id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
  endtask

  task automatic br(input logic [31:0] pc, input logic [31:0] res, input logic [31:0] bpc,
                    input logic pr, input logic [31:0] ppc);
    ex_fire = 1; ex_branch = 1; ex_pc = pc; ex_result = res;
    ex_branch_pc = bpc; ex_pred_res = pr; ex_pred_pc = ppc;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_rv"}, {31'd0, redirect_valid}, 32'd0);
    chk({nm, "_rpc"}, redirect_pc, 32'd0);
    chk({nm, "_flush"}, {31'd0, flush}, 32'd0);
    chk({nm, "_sif"}, {31'd0, stall_if}, 32'd0);
    chk({nm, "_sid"}, {31'd0, stall_id}, 32'd0);
    chk({nm, "_icf"}, {31'd0, icache_flush}, 32'd0);
    chk({nm, "_bcnt"}, branch_cnt, 32'd0);
    chk({nm, "_mcnt"}, mispred_cnt, 32'd0);
  endtask

  initial begin
    step(); step(); step();
    reset = 0;
    chk_on = 1;
    settle();
    chk_all_zero("reset");

    // Predicted not-taken beq resolves taken.
    step();
    br(32'h8000_0010, 32'h1, 32'h8000_0040, 1'b0, 32'h0);
    step(); clr_ex(); settle();
    chk("beq_rv", {31'd0, redirect_valid}, 32'd1);
    chk("beq_rpc", redirect_pc, 32'h8000_0040);
    chk("beq_flush", {31'd0, flush}, 32'd1);
    chk("beq_bcnt", branch_cnt, 32'd1);
    chk("beq_mcnt", mispred_cnt, 32'd1);
    step(); settle();
    chk("beq_flush_once", {31'd0, flush}, 32'd0);
    chk("beq_rv_once", {31'd0, redirect_valid}, 32'd0);

    // jalr correctly predicted (bit 0 of target dropped).
    ex_fire = 1; ex_jalr = 1; ex_pc = 32'h8000_0080; ex_result = 32'h8000_0103;
    ex_pred_res = 1; ex_pred_pc = 32'h8000_0102;
    step(); clr_ex(); settle();
    chk("jalr_ok_rv", {31'd0, redirect_valid}, 32'd0);
    chk("jalr_ok_flush", {31'd0, flush}, 32'd0);
    chk("jalr_ok_bcnt", branch_cnt, 32'd2);
    chk("jalr_ok_mcnt", mispred_cnt, 32'd1);
    // Same jalr, wrong predicted target.
    ex_fire = 1; ex_jalr = 1; ex_pc = 32'h8000_0080; ex_result = 32'h8000_0103;
    ex_pred_res = 1; ex_pred_pc = 32'h8000_0100;
    step(); clr_ex(); settle();
    chk("jalr_bad_rpc", redirect_pc, 32'h8000_0102);
    chk("jalr_bad_mcnt", mispred_cnt, 32'd2);
    step();

    // Predicted-taken branch at top of address space falls through: wrap.
    br(32'hFFFF_FFFC, 32'h0, 32'h1000_0000, 1'b1, 32'h1000_0000);
    step(); clr_ex(); settle();
    chk("wrap_rv", {31'd0, redirect_valid}, 32'd1);
    chk("wrap_rpc", redirect_pc, 32'h0000_0000);
    chk("wrap_bcnt", branch_cnt, 32'd4);
    step();

    // Load-use hazard on rs2.
    ex_valid = 1; ex_mem_ren = 1; ex_rd = 5'd5; id_valid = 1;
    id_rs2 = 5'd5; id_rs2_used = 1; settle();
    chk("lu_sid", {31'd0, stall_id}, 32'd1);
    chk("lu_sif", {31'd0, stall_if}, 32'd1);
    ex_rd = 5'd0; id_rs2 = 5'd0; settle();
    chk("lu_x0_sid", {31'd0, stall_id}, 32'd0);
    ex_rd = 5'd5; id_rs2 = 5'd6; id_rs1 = 5'd5; id_rs1_used = 0; settle();
    chk("lu_unused_sid", {31'd0, stall_id}, 32'd0);
    id_rs1_used = 1; settle();
    chk("lu_rs1_sid", {31'd0, stall_id}, 32'd1);

    // Mispredict together with load-use: stall now, flush wins next cycle.
    step();
    br(32'h8000_0500, 32'h1, 32'h8000_0600, 1'b0, 32'h0);
    settle();
    chk("mix_sid", {31'd0, stall_id}, 32'd1);
    step(); clr_ex(); settle();
    chk("mix_flush", {31'd0, flush}, 32'd1);
    chk("mix_rpc", redirect_pc, 32'h8000_0600);
    chk("mix_sid_forced", {31'd0, stall_id}, 32'd0);
    step(); settle();
    chk("mix_sid_back", {31'd0, stall_id}, 32'd1);
    clr_haz();
    step();

    // fence.i with lsu busy for 3 cycles.
    ex_fire = 1; ex_fence_i = 1; ex_pc = 32'h8000_0200; lsu_idle = 0;
    step(); clr_ex(); settle();
    chk("fi_flush", {31'd0, flush}, 32'd1);
    chk("fi_sif", {31'd0, stall_if}, 32'd1);
    step();
    icache_flush_done = 1;                   // stray pulse in DRAIN
    br(32'h8000_0700, 32'h1, 32'h8000_0800, 1'b0, 32'h0);  // ignored
    settle();
    chk("fi_flush_once", {31'd0, flush}, 32'd0);
    chk("fi_d2_icf", {31'd0, icache_flush}, 32'd0);
    step(); clr_ex(); icache_flush_done = 0; lsu_idle = 1; settle();
    chk("fi_d3_icf", {31'd0, icache_flush}, 32'd0);
    step(); settle();
    chk("fi_inv_icf", {31'd0, icache_flush}, 32'd1);
    chk("fi_inv_sif", {31'd0, stall_if}, 32'd1);
    step(); settle();
    chk("fi_inv2_icf", {31'd0, icache_flush}, 32'd1);
    icache_flush_done = 1;
    step(); icache_flush_done = 0; settle();
    chk("fi_res_rv", {31'd0, redirect_valid}, 32'd1);
    chk("fi_res_rpc", redirect_pc, 32'h8000_0204);
    chk("fi_res_icf", {31'd0, icache_flush}, 32'd0);
    chk("fi_bcnt", branch_cnt, 32'd5);
    chk("fi_mcnt", mispred_cnt, 32'd4);
    step(); settle();
    chk("fi_done_rv", {31'd0, redirect_valid}, 32'd0);
    chk("fi_done_sif", {31'd0, stall_if}, 32'd0);

    // fence.i with lsu already idle, then reset during INVAL.
    ex_fire = 1; ex_fence_i = 1; ex_pc = 32'h8000_0300;
    step(); clr_ex(); settle();
    chk("fi2_drain_icf", {31'd0, icache_flush}, 32'd0);
    step(); settle();
    chk("fi2_inval_icf", {31'd0, icache_flush}, 32'd1);
    reset = 1;
    step(); reset = 0; settle();
    chk_all_zero("rst_inval");
    step(); settle();
    chk("rst_inval_norv", {31'd0, redirect_valid}, 32'd0);
    chk("rst_inval_nosif", {31'd0, stall_if}, 32'd0);

    // Back-to-back mispredicts: the second is wrong-path.
    br(32'h8000_0900, 32'h1, 32'h8000_0A00, 1'b0, 32'h0);
    step();
    br(32'h8000_0904, 32'h1, 32'h8000_0B00, 1'b0, 32'h0);
    step(); clr_ex(); settle();
    chk("b2b_bcnt", branch_cnt, 32'd1);
    chk("b2b_mcnt", mispred_cnt, 32'd1);
    chk("b2b_rv", {31'd0, redirect_valid}, 32'd0);
    chk("b2b_flush", {31'd0, flush}, 32'd0);
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
Central pipeline sequencer for the 5-stage core. It resolves control flow at the EX→LS boundary: it compares the actual branch/jump outcome against the IFU prediction, issues PC redirects, and flushes the IF/ID/EX stage registers. It also runs the fence.i drain/invalidate sequence, inserts load-use bubbles, and keeps branch performance counters.

Parameters:
XLEN, 32, datapath/PC width
CNT_W, 32, performance counter width

Ports:
clock  in  1  clock
reset  in  1  synchronous active-high reset
ex_fire  in  1  EX stage output handshake (valid_next & ready_next) this cycle
ex_pc  in  XLEN  PC of the EX instruction
ex_result  in  XLEN  ALU result; bit0 = branch condition; full value = jalr target
ex_branch_pc  in  XLEN  precomputed target for jal/branch
ex_jal, ex_jalr, ex_branch, ex_fence_i  in  1 each  instruction class flags
ex_pred_res  in  1  IFU predicted-taken
ex_pred_pc  in  XLEN  IFU predicted target
ex_valid, ex_mem_ren  in  1 each  EX holds valid load
ex_rd  in  5  EX destination register
id_valid  in  1  ID holds valid instruction
id_rs1, id_rs2  in  5 each  ID sources
id_rs1_used, id_rs2_used  in  1 each  source actually read
lsu_idle  in  1  no outstanding store/load in LSU or bus
icache_flush_done  in  1  I-cache invalidation complete (pulse)
redirect_valid  out  1  load PC with redirect_pc
redirect_pc  out  XLEN  corrected fetch PC
flush  out  1  clear IF/ID/EX stage registers (drives each stage's clear)
stall_if  out  1  hold fetch
stall_id  out  1  hold ID, inject bubble into EX
icache_flush  out  1  invalidate request, level until done
branch_cnt, mispred_cnt  out  CNT_W each  performance counters

Behaviour:
- Reset: all outputs 0, FSM=IDLE, counters 0. Reset mid-sequence aborts fence.i with no redirect.
- Resolution applies only when ex_fire and FSM=IDLE and no flush is pending in the current cycle.
- taken = ex_jal | ex_jalr | (ex_branch & ex_result[0]).
- target = ex_jalr ? {ex_result[XLEN-1:1],1'b0} : ex_branch_pc.
- correct = taken ? target : ex_pc+4, with XLEN wrap-around modulo 2^XLEN.
- mispredict = (taken != ex_pred_res) | (taken & target != ex_pred_pc). Applies to control-flow instructions only; non-control instructions never mispredict.
- Mispredict at cycle N: at N+1, redirect_valid=1, redirect_pc=correct, flush=1 for exactly one cycle (all registered).
- Any ex_fire in cycle N+1 is wrong-path and is ignored.
- Counters: branch_cnt++ on each resolved jal/jalr/branch; mispred_cnt++ on each mispredict. Both wrap on overflow.
- FSM, states IDLE, DRAIN, INVAL, RESUME:
  - IDLE: resolved ex_fence_i → flush=1 next cycle, go to DRAIN.
  - DRAIN: stall_if=1; leave when lsu_idle=1 → INVAL.
  - INVAL: stall_if=1, icache_flush=1; icache_flush_done → RESUME.
  - RESUME: redirect_valid=1, redirect_pc=fence pc+4 (captured at entry), go to IDLE.
  - If lsu_idle is already 1 on DRAIN entry, spend exactly one cycle in DRAIN.
  - A done pulse outside INVAL is ignored.
- Load-use hazard: stall_id = ex_valid & ex_mem_ren & ex_rd≠0 & id_valid & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)). Combinational; stall_if = stall_id | FSM≠IDLE.
- Priority: flush/redirect over stall_id. stall_id is forced 0 while flush=1 or FSM≠IDLE.
- Simultaneous mispredict and load-use in the same cycle: mispredict is recorded; the stall is still asserted that cycle, then the flush follows.

Decomposition:
- Shared package: FSM state enum (IDLE/DRAIN/INVAL/RESUME), XLEN constant, NOP/bubble constants.
- One sub-module, branch_resolve: combinational taken/target/correct/mispredict computation, reused by trace/difftest.

Test Plan:
- Predicted not-taken beq at pc 0x80000010, ex_result[0]=1, ex_branch_pc=0x80000040 → next cycle redirect_valid=1, redirect_pc=0x80000040, flush=1 for one cycle; mispred_cnt=1, branch_cnt=1.
- jalr with ex_result=0x80000103, ex_pred_res=1, ex_pred_pc=0x80000102 → no redirect, no flush; branch_cnt=1, mispred_cnt=0. Repeat with ex_pred_pc=0x80000100 → redirect_pc=0x80000102.
- Taken-predicted branch at pc 0xFFFFFFFC resolves not-taken → redirect_pc=0x00000000 (wrap).
- Load to x5 in EX, ID reads rs2=x5 with id_rs2_used=1 → stall_id=1, stall_if=1. Same case with ex_rd=0 → no stall.
- fence.i at 0x80000200 with lsu_idle low for 3 cycles → flush pulse, 3 cycles in DRAIN, icache_flush held until done, then redirect_pc=0x80000204. Assert reset during INVAL → all outputs 0, no redirect.
- Mispredict followed by ex_fire the next cycle carrying another mispredicting branch → second branch ignored; counters increment once.
